// File: rtl/jericalla_pkg.sv
// Shared Jericalla constants and the program-loader state encoding.
package jericalla_pkg;

   localparam int INST_W = 18;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_B0,
      ST_B1,
      ST_B2,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } ld_state_e;

   // A session length is usable only if it names 1..DEPTH words.
   function automatic logic len_ok(input logic [7:0] n);
      return (n != 8'd0) && (n <= 8'(DEPTH));
   endfunction

   // The third byte of a word carries only two payload bits; the rest must be zero.
   function automatic logic hi_byte_ok(input logic [7:0] b);
      return (b[7:2] == 6'd0);
   endfunction

endpackage

// File: rtl/jericalla_prog_loader.sv
// Program loader: streams a length byte plus 3-byte little-endian words into
// the instruction memory write port, holding the PC in reset until done.
module jericalla_prog_loader
   import jericalla_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [7:0]        byte_in_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [INST_W-1:0] mem_data_o,
   output logic              core_reset_o,
   output logic              load_done_o,
   output logic              err_o,
   output logic [ADDR_W:0]   count_o
);

   ld_state_e         state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic [INST_W-1:0] data_q, data_d;
   logic              xfer;
   logic [ADDR_W:0]   count_inc;

   // byte_ready is a pure state decode, so xfer never feeds back into it.
   assign xfer      = byte_valid_i & byte_ready_o;
   assign count_inc = count_q + 1'b1;

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; start only matters when no session is in progress.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: if (start_i) state_d = ST_LEN;
         ST_LEN:   if (xfer) state_d = len_ok(byte_in_i) ? ST_B0 : ST_ERR;
         ST_B0:    if (xfer) state_d = ST_B1;
         ST_B1:    if (xfer) state_d = ST_B2;
         ST_B2:    if (xfer) state_d = hi_byte_ok(byte_in_i) ? ST_WRITE : ST_ERR;
         ST_WRITE: state_d = (count_inc == n_q) ? ST_DONE : ST_B0;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode from the state register only.
   always_comb begin
      byte_ready_o = 1'b0;
      mem_we_o     = 1'b0;
      core_reset_o = 1'b1;
      load_done_o  = 1'b0;
      err_o        = 1'b0;
      unique case (state_q)
         ST_LEN, ST_B0, ST_B1, ST_B2: byte_ready_o = 1'b1;
         ST_WRITE: mem_we_o = 1'b1;
         ST_DONE: begin
            load_done_o  = 1'b1;
            core_reset_o = 1'b0;
         end
         ST_ERR:  err_o = 1'b1;
         default: ;
      endcase
   end

   // Datapath next state: session length, word counter and word assembly.
   always_comb begin
      count_d = count_q;
      n_d     = n_q;
      data_d  = data_q;
      unique case (state_q)
         ST_LEN: if (xfer && len_ok(byte_in_i)) begin
            n_d     = byte_in_i[ADDR_W:0];
            count_d = '0;
         end
         ST_B0:    if (xfer) data_d[7:0]   = byte_in_i;
         ST_B1:    if (xfer) data_d[15:8]  = byte_in_i;
         ST_B2:    if (xfer) data_d[17:16] = byte_in_i[1:0];
         ST_WRITE: count_d = count_inc;
         default: ;
      endcase
   end

   // Datapath registers; reset discards any partially assembled word.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
         n_q     <= '0;
         data_q  <= '0;
      end else begin
         count_q <= count_d;
         n_q     <= n_d;
         data_q  <= data_d;
      end
   end

   // The address never wraps inside a session, since count stops at N <= DEPTH.
   assign mem_addr_o = count_q[ADDR_W-1:0];
   assign mem_data_o = data_q;
   assign count_o    = count_q;

endmodule

// File: tb/tb_jericalla_prog_loader.sv
// Scoreboard bench for jericalla_prog_loader: stimulus pushes expected writes,
// a monitor pops and compares on every mem_we.
module tb_jericalla_prog_loader;

   logic        clk = 1'b0;
   logic        reset, start, byte_valid;
   logic [7:0]  byte_in;
   logic        byte_ready, mem_we, core_reset, load_done, err;
   logic [3:0]  mem_addr;
   logic [17:0] mem_data;
   logic [4:0]  count;

   int tests = 0;
   int fails = 0;

   typedef struct { int addr; int data; } wr_t;
   wr_t exp_q[$];

   jericalla_prog_loader dut (
      .clk_i(clk), .reset_i(reset), .start_i(start),
      .byte_in_i(byte_in), .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
      .core_reset_o(core_reset), .load_done_o(load_done), .err_o(err),
      .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr=%0d data=0x%0h, none expected", mem_addr, mem_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (int'(mem_addr) != e.addr || int'(mem_data) != e.data) begin
               fails++;
               $display("FAIL write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                        mem_addr, mem_data, e.addr, e.data);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte; returns at the negedge after the edge that consumed it.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int cyc;
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) begin
            byte_valid = 1'b0;
            @(negedge clk);
         end
      end
      byte_in    = b;
      byte_valid = 1'b1;
      cyc = 0;
      while (!byte_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!byte_ready) begin
         tests++; fails++;
         $display("FAIL byte_timeout: byte_ready stuck 0, required 1");
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   // Reference: a legal 18-bit word is three little-endian bytes; address = word index.
   task automatic send_word(input int idx, input int w, input bit gaps);
      wr_t e;
      e.addr = idx;
      e.data = w;
      exp_q.push_back(e);
      send_byte(8'(w), gaps);
      send_byte(8'(w >> 8), gaps);
      send_byte(8'(w >> 16), gaps);
   endtask

   task automatic run_session(input int n, input bit gaps, input string tag);
      pulse_start();
      send_byte(8'(n), gaps);
      for (int i = 0; i < n; i++) send_word(i, int'($urandom) & 32'h3FFFF, gaps);
      check({tag, "_we"}, int'(mem_we), 1);
      @(negedge clk);
      check({tag, "_done"}, int'(load_done), 1);
      check({tag, "_core_reset"}, int'(core_reset), 0);
      check({tag, "_count"}, int'(count), n);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      cycles(2);
      reset = 1'b0;
      cycles(5);
      check("rst_core_reset", int'(core_reset), 1);
      check("rst_load_done", int'(load_done), 0);
      check("rst_byte_ready", int'(byte_ready), 0);
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_err", int'(err), 0);
      check("rst_count", int'(count), 0);

      // Two fixed words with valid held continuously.
      pulse_start();
      check("len_ready", int'(byte_ready), 1);
      send_byte(8'h02, 1'b0);
      send_word(0, 18'h31234, 1'b0);
      send_word(1, 18'h1ABCD, 1'b0);
      check("fix_we", int'(mem_we), 1);
      check("fix_ready_in_write", int'(byte_ready), 0);
      check("fix_done_not_yet", int'(load_done), 0);
      @(negedge clk);
      check("fix_done", int'(load_done), 1);
      check("fix_core_reset", int'(core_reset), 0);
      check("fix_count", int'(count), 2);
      check("fix_we_one_cycle", int'(mem_we), 0);

      // New start from DONE re-asserts core reset.
      pulse_start();
      check("restart_core_reset", int'(core_reset), 1);
      check("restart_done_clr", int'(load_done), 0);
      // Full-depth session with random valid gaps.
      send_byte(8'h10, 1'b1);
      for (int i = 0; i < 16; i++) send_word(i, int'($urandom) & 32'h3FFFF, 1'b1);
      @(negedge clk);
      check("full_done", int'(load_done), 1);
      check("full_count", int'(count), 16);

      // Length too large.
      pulse_start();
      send_byte(8'h11, 1'b0);
      check("badlen_err", int'(err), 1);
      check("badlen_core_reset", int'(core_reset), 1);
      check("badlen_ready", int'(byte_ready), 0);
      cycles(3);
      run_session(1, 1'b0, "recover");
      check("recover_err", int'(err), 0);

      // Zero length.
      pulse_start();
      send_byte(8'h00, 1'b0);
      check("zerolen_err", int'(err), 1);

      // Bad third byte on the second word; start in B1 is ignored.
      pulse_start();
      send_byte(8'h03, 1'b0);
      send_byte(8'h78, 1'b0);
      pulse_start();
      check("midload_start_ready", int'(byte_ready), 1);
      check("midload_start_err", int'(err), 0);
      begin
         wr_t e;
         e.addr = 0; e.data = 18'h25678;
         exp_q.push_back(e);
      end
      send_byte(8'h56, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h04, 1'b0);
      check("hibyte_err", int'(err), 1);
      check("hibyte_core_reset", int'(core_reset), 1);
      check("hibyte_count", int'(count), 1);
      cycles(3);

      // Reset in B1 of the second word.
      pulse_start();
      send_byte(8'h03, 1'b0);
      send_word(0, int'($urandom) & 32'h3FFFF, 1'b0);
      send_byte(8'hAA, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_count", int'(count), 0);
      check("midrst_core_reset", int'(core_reset), 1);
      check("midrst_ready", int'(byte_ready), 0);
      check("midrst_done", int'(load_done), 0);
      byte_in = 8'h55; byte_valid = 1'b1;
      cycles(6);
      byte_valid = 1'b0;
      check("midrst_ready_idle", int'(byte_ready), 0);

      // Random-length sessions with random gaps.
      for (int s = 0; s < 4; s++)
         run_session(int'($urandom_range(1, 16)), 1'b1, "rand");

      cycles(3);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
